// File: rtl/hba_reg_slave.sv
// HBA bus responder: INTR_EN, W1C STATUS and NUM_REGS general RW registers with a one-cycle xferack.
// Optional HBA_REG_SLAVE_WSTROBE_EN adds per-register write strobes aligned with slave_xferack.
module hba_reg_slave #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int NUM_REGS          = 4
) (
  input  logic                           hba_clk,
  input  logic                           hba_reset_n,
  input  logic                           hba_select,
  input  logic                           hba_rnw,
  input  logic [ADDR_WIDTH-1:0]          hba_abus,
  input  logic [DBUS_WIDTH-1:0]          hba_dbus,
  input  logic [DBUS_WIDTH-1:0]          hw_status_set,
  output logic                           slave_xferack,
  output logic [DBUS_WIDTH-1:0]          slave_dbus,
  output logic [NUM_REGS*DBUS_WIDTH-1:0] slave_reg,
`ifdef HBA_REG_SLAVE_WSTROBE_EN
  output logic [NUM_REGS-1:0]            slave_wstrobe,
`endif
  output logic                           slave_intr
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_RELEASE} state_t;

  state_t                  state_q;
  logic                    xferack_q;
  logic [DBUS_WIDTH-1:0]   dbus_q;
  logic [DBUS_WIDTH-1:0]   intr_en_q;
  logic [DBUS_WIDTH-1:0]   status_q;
  logic [DBUS_WIDTH-1:0]   status_d;
  logic [DBUS_WIDTH-1:0]   regs_q [NUM_REGS];
  logic                    intr_q;
`ifdef HBA_REG_SLAVE_WSTROBE_EN
  logic [NUM_REGS-1:0]     wstrobe_q;
`endif

  logic [PERIPH_ADDR_WIDTH-1:0] slot;
  logic [REG_ADDR_WIDTH-1:0]    reg_sel;
  logic                         hit;
  logic [DBUS_WIDTH-1:0]        rd_data;
  logic [DBUS_WIDTH-1:0]        w1c_mask;

  assign slot    = hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH];
  assign reg_sel = hba_abus[REG_ADDR_WIDTH-1:0];
  assign hit     = (state_q == IDLE) && hba_select &&
                   (slot == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));

  always_comb begin
    rd_data = '0;
    if (reg_sel == REG_ADDR_WIDTH'(0)) rd_data = intr_en_q;
    if (reg_sel == REG_ADDR_WIDTH'(1)) rd_data = status_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (reg_sel == REG_ADDR_WIDTH'(k + 2)) rd_data = regs_q[k];
    end
  end

  // Hardware set is OR-ed after the clear so a coincident set wins.
  always_comb begin
    w1c_mask = '0;
    if (hit && !hba_rnw && (reg_sel == REG_ADDR_WIDTH'(1))) w1c_mask = hba_dbus;
    status_d = (status_q & ~w1c_mask) | hw_status_set;
  end

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      state_q   <= IDLE;
      xferack_q <= 1'b0;
      dbus_q    <= '0;
      intr_en_q <= '0;
      status_q  <= '0;
      intr_q    <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
`ifdef HBA_REG_SLAVE_WSTROBE_EN
      wstrobe_q <= '0;
`endif
    end else begin
      xferack_q <= 1'b0;
      dbus_q    <= '0;
      status_q  <= status_d;
      intr_q    <= |(status_q & intr_en_q);
`ifdef HBA_REG_SLAVE_WSTROBE_EN
      wstrobe_q <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (hit) begin
            state_q   <= ACK;
            xferack_q <= 1'b1;
            if (hba_rnw) begin
              dbus_q <= rd_data;
            end else begin
              if (reg_sel == REG_ADDR_WIDTH'(0)) intr_en_q <= hba_dbus;
              for (int k = 0; k < NUM_REGS; k++) begin
                if (reg_sel == REG_ADDR_WIDTH'(k + 2)) begin
                  regs_q[k] <= hba_dbus;
`ifdef HBA_REG_SLAVE_WSTROBE_EN
                  wstrobe_q[k] <= 1'b1;
`endif
                end
              end
            end
          end
        end
        ACK:          state_q <= WAIT_RELEASE;
        WAIT_RELEASE: if (!hba_select) state_q <= IDLE;
        default:      state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign slave_reg[g*DBUS_WIDTH +: DBUS_WIDTH] = regs_q[g];
  end

  assign slave_xferack = xferack_q;
  assign slave_dbus    = dbus_q;
  assign slave_intr    = intr_q;
`ifdef HBA_REG_SLAVE_WSTROBE_EN
  assign slave_wstrobe = wstrobe_q;
`endif

endmodule

// File: tb/tb_hba_reg_slave.sv
// Directed bench for hba_reg_slave at slot 3: vector table of single transfers plus hand sequences.
module tb_hba_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        select;
  logic        rnw;
  logic [11:0] abus;
  logic [7:0]  dbus;
  logic [7:0]  hw_set;
  logic        xferack;
  logic [7:0]  sdbus;
  logic [31:0] sreg;
  logic        intr;
`ifdef HBA_REG_SLAVE_WSTROBE_EN
  logic [3:0]  wstrobe;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hba_reg_slave #(.PERIPH_ADDR(3)) dut (
    .hba_clk       (clk),
    .hba_reset_n   (rst_n),
    .hba_select    (select),
    .hba_rnw       (rnw),
    .hba_abus      (abus),
    .hba_dbus      (dbus),
    .hw_status_set (hw_set),
    .slave_xferack (xferack),
    .slave_dbus    (sdbus),
    .slave_reg     (sreg),
`ifdef HBA_REG_SLAVE_WSTROBE_EN
    .slave_wstrobe (wstrobe),
`endif
    .slave_intr    (intr)
  );

  typedef struct {
    logic        rnw;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        exp_ack;
    logic [7:0]  exp_dbus;
    logic [31:0] exp_regs;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete transfer; returns what was seen in the cycle after select was sampled.
  task automatic xfer(input logic r, input logic [11:0] a, input logic [7:0] d,
                      output logic ack, output logic [7:0] rd, output logic [31:0] regs);
    select = 1'b1; rnw = r; abus = a; dbus = d;
    tick();
    ack = xferack; rd = sdbus; regs = sreg;
    select = 1'b0; abus = 12'h000; dbus = 8'h00;
    tick();
    check("ack_one_cycle", {31'b0, xferack}, 32'h0);
    check("dbus_after_ack", {24'b0, sdbus}, 32'h0);
    tick();
  endtask

  logic        ack;
  logic [7:0]  rd;
  logic [31:0] regs;
  int          acks;

  initial begin
    vecs[0]  = '{1'b0, 12'h302, 8'hA5, 1'b1, 8'h00, 32'h0000_00A5};
    vecs[1]  = '{1'b1, 12'h302, 8'h00, 1'b1, 8'hA5, 32'h0000_00A5};
    vecs[2]  = '{1'b0, 12'h502, 8'h5A, 1'b0, 8'h00, 32'h0000_00A5};
    vecs[3]  = '{1'b1, 12'h502, 8'h00, 1'b0, 8'h00, 32'h0000_00A5};
    vecs[4]  = '{1'b0, 12'h305, 8'h3C, 1'b1, 8'h00, 32'h3C00_00A5};
    vecs[5]  = '{1'b1, 12'h305, 8'h00, 1'b1, 8'h3C, 32'h3C00_00A5};
    vecs[6]  = '{1'b0, 12'h3FF, 8'h77, 1'b1, 8'h00, 32'h3C00_00A5};
    vecs[7]  = '{1'b1, 12'h3FF, 8'h00, 1'b1, 8'h00, 32'h3C00_00A5};
    vecs[8]  = '{1'b0, 12'h300, 8'h04, 1'b1, 8'h00, 32'h3C00_00A5};
    vecs[9]  = '{1'b1, 12'h300, 8'h00, 1'b1, 8'h04, 32'h3C00_00A5};
    vecs[10] = '{1'b1, 12'h301, 8'h00, 1'b1, 8'h00, 32'h3C00_00A5};
    vecs[11] = '{1'b0, 12'h303, 8'hFF, 1'b1, 8'h00, 32'h3C00_FFA5};
    vecs[12] = '{1'b1, 12'h303, 8'h00, 1'b1, 8'hFF, 32'h3C00_FFA5};
    vecs[13] = '{1'b1, 12'h306, 8'h00, 1'b1, 8'h00, 32'h3C00_FFA5};

    rst_n = 1'b0; select = 1'b0; rnw = 1'b0; abus = '0; dbus = '0; hw_set = '0;
    #2;
    check("reset_ack",  {31'b0, xferack}, 32'h0);
    check("reset_dbus", {24'b0, sdbus},   32'h0);
    check("reset_regs", sreg,             32'h0);
    check("reset_intr", {31'b0, intr},    32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      xfer(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, ack, rd, regs);
      check($sformatf("vec%0d_ack", i),  {31'b0, ack}, {31'b0, vecs[i].exp_ack});
      check($sformatf("vec%0d_dbus", i), {24'b0, rd},  {24'b0, vecs[i].exp_dbus});
      check($sformatf("vec%0d_regs", i), regs,         vecs[i].exp_regs);
      check($sformatf("vec%0d_intr", i), {31'b0, intr}, 32'h0);
    end

    // Select held high for 10 cycles: exactly one ack, then re-ack after release.
    select = 1'b1; rnw = 1'b1; abus = 12'h302;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (xferack) acks++;
    end
    check("held_select_acks", acks, 1);
    select = 1'b0;
    tick();
    check("released_no_ack", {31'b0, xferack}, 32'h0);
    select = 1'b1;
    tick();
    check("reselect_ack",  {31'b0, xferack}, 32'h1);
    check("reselect_dbus", {24'b0, sdbus},   32'hA5);
    select = 1'b0;
    tick(); tick();

    // Status / interrupt with INTR_EN = 0x04 from the table.
    hw_set = 8'h06;
    tick();
    hw_set = 8'h00;
    tick();
    check("intr_raised", {31'b0, intr}, 32'h1);
    xfer(1'b1, 12'h301, 8'h00, ack, rd, regs);
    check("status_read1", {24'b0, rd}, 32'h06);
    xfer(1'b1, 12'h301, 8'h00, ack, rd, regs);
    check("status_read_sticky", {24'b0, rd}, 32'h06);

    select = 1'b1; rnw = 1'b0; abus = 12'h301; dbus = 8'h04; hw_set = 8'h04;
    tick();
    hw_set = 8'h00; select = 1'b0;
    tick(); tick();
    xfer(1'b1, 12'h301, 8'h00, ack, rd, regs);
    check("status_set_wins", {24'b0, rd}, 32'h06);
    check("intr_still_set", {31'b0, intr}, 32'h1);

    xfer(1'b0, 12'h301, 8'h04, ack, rd, regs);
    xfer(1'b1, 12'h301, 8'h00, ack, rd, regs);
    check("status_w1c", {24'b0, rd}, 32'h02);
    check("intr_cleared", {31'b0, intr}, 32'h0);

    // Reset asserted in the middle of an ACK cycle.
    hw_set = 8'h04;
    tick();
    hw_set = 8'h00;
    tick();
    check("intr_pre_reset", {31'b0, intr}, 32'h1);
    select = 1'b1; rnw = 1'b1; abus = 12'h301;
    tick();
    check("pre_reset_ack",  {31'b0, xferack}, 32'h1);
    check("pre_reset_dbus", {24'b0, sdbus},   32'h06);
    rst_n = 1'b0;
    #1;
    check("midack_reset_ack",  {31'b0, xferack}, 32'h0);
    check("midack_reset_dbus", {24'b0, sdbus},   32'h0);
    check("midack_reset_intr", {31'b0, intr},    32'h0);
    check("midack_reset_regs", sreg,             32'h0);
    select = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    xfer(1'b1, 12'h300, 8'h00, ack, rd, regs);
    check("post_reset_intren", {23'b0, ack, rd}, 32'h100);
    xfer(1'b1, 12'h301, 8'h00, ack, rd, regs);
    check("post_reset_status", {23'b0, ack, rd}, 32'h100);
    xfer(1'b1, 12'h305, 8'h00, ack, rd, regs);
    check("post_reset_reg3", {23'b0, ack, rd}, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
